latch_pipe_stage: RTL and testbench
===================================

Name: latch_pipe_stage

Overview:
- Generic pipeline-stage register. Successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field, each with a parametrised width.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so stalls no longer need a combinational backpressure chain.
- Bubbles carry an all-zero control field, so downstream wreg/wmem are never asserted spuriously. It also supports a synchronous flush and a saturating stall-cycle counter for performance profiling.

Parameters:
- CTRL_W, 8, width of control field (bit 0 = wmem, bit 1 = wreg by package convention)
- DATA_W, 96, width of data payload (operands, p4, register numbers concatenated)
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control field of offered entry
- in_data  in  DATA_W  data field of offered entry
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream consumes this cycle
- out_ctrl  out  CTRL_W  control field of head entry; 0 when out_valid=0
- out_data  out  DATA_W  data field of head entry; holds last value when invalid
- stat_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (clrn=0, async): both slots invalid; all ctrl/data registers = 0; stall_cnt = 0; in_ready = 1 after release.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main slot M drives the outputs. Skid slot S exists only when SKID=1.
- SKID=1 occupancy states:
  - EMPTY (M=0, S=0): accept -> ONE, M <= in.
  - ONE (M=1, S=0):
    - accept & drain -> ONE, M <= in.
    - accept & !drain -> FULL, S <= in.
    - drain & !accept -> EMPTY.
    - Neither -> hold.
  - FULL (M=1, S=1): in_ready=0. drain -> ONE, M <= S, S cleared.
- SKID=1: in_ready = !S.valid, registered, with no combinational path from out_ready.
- SKID=0: in_ready = !M.valid | out_ready (combinational). M <= in on accept. M cleared on drain & !accept.
- Latency: one cycle from accept to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Bubble rule: whenever M becomes invalid, M.ctrl <= 0 in the same edge; M.data is retained.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush.
- Flush (sync, highest priority):
  - Next edge: M and S invalid, all ctrl registers = 0, data retained.
  - An accept in the flush cycle is discarded.
  - in_ready = 1 in the cycle after the flush.
  - Flush does not alter stall_cnt.
- stall_cnt:
  - stat_clr -> 0. stat_clr has priority over increment.
  - Otherwise, when out_valid & !out_ready, increment; hold at 2^CNT_W-1.
- Downstream sees out_ctrl = 0 whenever out_valid = 0, in every state, including after reset and after flush.
- Reset asserted mid-operation clears everything immediately. No partial entry is presented after release.

Decomposition:
- Shared package pipe_pkg:
  - Control-bit index constants: CTRL_WMEM=0, CTRL_WREG=1, CTRL_M2REG=2, CTRL_JAL=3, CTRL_ALUC_LSB=4.
  - Occupancy state encoding: EMPTY=2'b00, ONE=2'b01, FULL=2'b11.
  - Default width constants.
- One sub-module, pipe_slot:
  - Holds valid, ctrl and data.
  - Inputs: load, clear.
  - On clear, sets valid=0 and ctrl=0.
  - Instantiated for M, and for S when SKID=1.

Test Plan:
- Reset: hold clrn=0 with in_valid=1 and in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1 on release.
- Streaming (SKID=1): present ctrl=8'h03, data=k for k=1..10, with out_ready=1 throughout -> out_data sequence 1..10, one cycle after each accept, no gaps; stall_cnt=0.
- Backpressure (SKID=1): out_ready=0 for 5 cycles while upstream sends 1,2,3 -> entries 1 and 2 accepted, in_ready=0 from cycle 3, stall_cnt=4. Then out_ready=1 -> 1,2,3 emerge in order.
- Flush in FULL with a simultaneous in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the offered entry never appears.
- SKID=0: out_ready toggles 1,0,1,0 under continuous in_valid -> in_ready follows out_ready combinationally while M is valid; order preserved; no bubble has out_ctrl!=0.
- Counter: CNT_W=4, stall 20 cycles -> stall_cnt saturates at 15. stat_clr pulse -> 0. stat_clr together with a stall cycle -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for generic pipeline-stage registers: control-bit
// positions, occupancy encoding and default widths.
package pipe_pkg;

  localparam int CTRL_WMEM     = 0;
  localparam int CTRL_WREG     = 1;
  localparam int CTRL_M2REG    = 2;
  localparam int CTRL_JAL      = 3;
  localparam int CTRL_ALUC_LSB = 4;

  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 96;
  localparam int DEF_CNT_W  = 16;

  // Encoding mirrors {S.valid, M.valid}, so FULL implies both slots hold data.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid bit, control and data fields.
// clear beats load; clearing zeroes ctrl so a bubble never carries write enables.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/latch_pipe_stage.sv
// Generic valid/ready pipeline register, one cycle accept-to-output, optional
// 2-entry skid buffer (registered in_ready), sync flush, saturating stall counter.
module latch_pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              accept;
  logic              drain;
  logic              m_vld;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              m_load;
  logic              m_clear;
  logic [CTRL_W-1:0] m_ld_ctrl;
  logic [DATA_W-1:0] m_ld_data;

  assign accept = in_valid & in_ready;
  assign drain  = m_vld & out_ready;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_m (
    .clk     (clk),
    .clrn    (clrn),
    .load    (m_load),
    .clear   (m_clear),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .valid   (m_vld),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      occ_e              state;
      occ_e              state_nxt;
      logic              s_vld;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;
      logic              s_load;
      logic              s_clear;
      logic              from_s;

      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_s (
        .clk     (clk),
        .clrn    (clrn),
        .load    (s_load),
        .clear   (s_clear),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (s_vld),
        .ctrl    (s_ctrl),
        .data    (s_data)
      );

      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          state <= EMPTY;
        end else begin
          state <= state_nxt;
        end
      end

      // Derived from the state register only: out_ready never reaches in_ready.
      assign in_ready  = (state != FULL);
      assign m_ld_ctrl = from_s ? s_ctrl : in_ctrl;
      assign m_ld_data = from_s ? s_data : in_data;

      always_comb begin
        state_nxt = state;
        m_load    = 1'b0;
        m_clear   = 1'b0;
        s_load    = 1'b0;
        s_clear   = 1'b0;
        from_s    = 1'b0;
        if (flush) begin
          m_clear   = 1'b1;
          s_clear   = 1'b1;
          state_nxt = EMPTY;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                m_load    = 1'b1;
                state_nxt = ONE;
              end
            end
            ONE: begin
              if (accept && drain) begin
                m_load = 1'b1;
              end else if (accept) begin
                s_load    = 1'b1;
                state_nxt = FULL;
              end else if (drain) begin
                m_clear   = 1'b1;
                state_nxt = EMPTY;
              end
            end
            FULL: begin
              if (drain) begin
                m_load    = 1'b1;
                from_s    = 1'b1;
                s_clear   = 1'b1;
                state_nxt = ONE;
              end
            end
            default: begin
              m_clear   = 1'b1;
              s_clear   = 1'b1;
              state_nxt = EMPTY;
            end
          endcase
        end
      end
    end else begin : g_flow
      assign in_ready  = !m_vld | out_ready;
      assign m_ld_ctrl = in_ctrl;
      assign m_ld_data = in_data;

      always_comb begin
        m_load  = accept & !flush;
        m_clear = flush | (drain & !accept);
      end
    end
  endgenerate

  assign out_valid = m_vld;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (m_vld && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_latch_pipe_stage.sv
// Directed bench: table of vectors for the skid configuration, plus hand-written
// sequences for mid-operation reset, the combinational-ready variant and counter saturation.
module tb_latch_pipe_stage;

  logic clk;
  logic clrn;

  // skid instance
  logic        a_fl, a_iv, a_ir, a_ov, a_or, a_sc;
  logic [7:0]  a_ic, a_oc;
  logic [95:0] a_id, a_od;
  logic [15:0] a_cnt;
  // combinational-ready instance
  logic        b_fl, b_iv, b_ir, b_ov, b_or, b_sc;
  logic [7:0]  b_ic, b_oc;
  logic [95:0] b_id, b_od;
  logic [15:0] b_cnt;
  // narrow-counter instance
  logic        c_fl, c_iv, c_ir, c_ov, c_or, c_sc;
  logic [7:0]  c_ic, c_oc;
  logic [95:0] c_id, c_od;
  logic [3:0]  c_cnt;

  int n_chk;
  int n_fail;

  latch_pipe_stage #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .clrn(clrn), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_ctrl(a_ic), .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
    .out_ctrl(a_oc), .out_data(a_od), .stat_clr(a_sc), .stall_cnt(a_cnt)
  );

  latch_pipe_stage #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .clrn(clrn), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_ctrl(b_ic), .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
    .out_ctrl(b_oc), .out_data(b_od), .stat_clr(b_sc), .stall_cnt(b_cnt)
  );

  latch_pipe_stage #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .clrn(clrn), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
    .in_ctrl(c_ic), .in_data(c_id), .out_valid(c_ov), .out_ready(c_or),
    .out_ctrl(c_oc), .out_data(c_od), .stat_clr(c_sc), .stall_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [7:0]  ic;
    logic [95:0] id;
    logic        ordy;
    logic        fl;
    logic        sc;
    logic        eov;
    logic [7:0]  eoc;
    logic [95:0] eod;
    logic        eir;
    logic [15:0] esc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int iv, input int ic, input int id, input int ordy,
                              input int fl, input int sc, input int eov, input int eoc,
                              input int eod, input int eir, input int esc);
    vec_t v;
    v.iv   = 1'(iv);
    v.ic   = 8'(ic);
    v.id   = 96'(id);
    v.ordy = 1'(ordy);
    v.fl   = 1'(fl);
    v.sc   = 1'(sc);
    v.eov  = 1'(eov);
    v.eoc  = 8'(eoc);
    v.eod  = 96'(eod);
    v.eir  = 1'(eir);
    v.esc  = 16'(esc);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Combinational-ready sequence: out_ready toggles under continuous offers.
  int b_ordy[6] = '{1, 1, 0, 1, 0, 1};
  int b_iv_t[6] = '{1, 1, 1, 1, 1, 0};
  int b_d[6]    = '{1, 2, 3, 3, 4, 0};
  int b_eir[6]  = '{1, 1, 0, 1, 0, 1};
  int b_eov[6]  = '{1, 1, 1, 1, 1, 0};
  int b_eod[6]  = '{1, 2, 2, 3, 3, 3};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clrn   = 1'b0;
    {a_fl, a_or, a_sc, b_fl, b_or, b_sc, c_fl, c_or, c_sc} = '0;
    a_iv = 1'b1; a_ic = 8'hFF; a_id = 96'h1234;
    b_iv = 1'b1; b_ic = 8'hFF; b_id = 96'h1234;
    c_iv = 1'b1; c_ic = 8'hFF; c_id = 96'h1234;

    // Streaming k=1..10 then idle
    for (int k = 1; k <= 10; k++) vecs.push_back(mk(1, 8'h03, k, 1, 0, 0, 1, 8'h03, k, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 10, 1, 0));
    // Backpressure: 5 stalled cycles, then release
    vecs.push_back(mk(1, 8'h03, 1, 0, 0, 0, 1, 8'h03, 1, 1, 0));
    vecs.push_back(mk(1, 8'h03, 2, 0, 0, 0, 1, 8'h03, 1, 0, 1));
    vecs.push_back(mk(1, 8'h03, 3, 0, 0, 0, 1, 8'h03, 1, 0, 2));
    vecs.push_back(mk(1, 8'h03, 3, 0, 0, 0, 1, 8'h03, 1, 0, 3));
    vecs.push_back(mk(1, 8'h03, 3, 0, 0, 0, 1, 8'h03, 1, 0, 4));
    vecs.push_back(mk(1, 8'h03, 3, 1, 0, 0, 1, 8'h03, 2, 1, 4));
    vecs.push_back(mk(1, 8'h03, 3, 1, 0, 0, 1, 8'h03, 3, 1, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 4));
    // Flush in FULL with an offer pending
    vecs.push_back(mk(1, 8'h03, 'h21, 0, 0, 0, 1, 8'h03, 'h21, 1, 4));
    vecs.push_back(mk(1, 8'h03, 'h22, 0, 0, 0, 1, 8'h03, 'h21, 0, 5));
    vecs.push_back(mk(1, 8'h03, 'h23, 1, 1, 0, 0, 0, 'h21, 1, 5));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 'h21, 1, 5));
    // Flush in ONE discards a real accept
    vecs.push_back(mk(1, 8'h03, 'h31, 0, 0, 0, 1, 8'h03, 'h31, 1, 5));
    vecs.push_back(mk(1, 8'h03, 'h32, 1, 1, 0, 0, 0, 'h31, 1, 5));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 'h31, 1, 5));
    // stat_clr, then a bubble after an all-ones control word
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 'h31, 1, 0));
    vecs.push_back(mk(1, 8'hFF, 'h41, 1, 0, 0, 1, 8'hFF, 'h41, 1, 0));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 0, 0, 0, 0, 'h41, 1, 0));

    // Reset held with an offer present
    tick();
    tick();
    chk("rst_a_ov", 128'(a_ov), 128'(0));
    chk("rst_a_oc", 128'(a_oc), 128'(0));
    chk("rst_a_cnt", 128'(a_cnt), 128'(0));
    chk("rst_b_ov", 128'(b_ov), 128'(0));
    chk("rst_b_oc", 128'(b_oc), 128'(0));
    chk("rst_c_ov", 128'(c_ov), 128'(0));
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    clrn = 1'b1;
    #1;
    chk("rst_a_ir", 128'(a_ir), 128'(1));
    chk("rst_b_ir", 128'(b_ir), 128'(1));
    tick();
    chk("rst_a_ov_rel", 128'(a_ov), 128'(0));
    chk("rst_a_od_rel", 128'(a_od), 128'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      a_iv = vecs[i].iv;
      a_ic = vecs[i].ic;
      a_id = vecs[i].id;
      a_or = vecs[i].ordy;
      a_fl = vecs[i].fl;
      a_sc = vecs[i].sc;
      tick();
      chk($sformatf("v%0d_ov", i), 128'(a_ov), 128'(vecs[i].eov));
      chk($sformatf("v%0d_oc", i), 128'(a_oc), 128'(vecs[i].eoc));
      chk($sformatf("v%0d_od", i), 128'(a_od), 128'(vecs[i].eod));
      chk($sformatf("v%0d_ir", i), 128'(a_ir), 128'(vecs[i].eir));
      chk($sformatf("v%0d_cnt", i), 128'(a_cnt), 128'(vecs[i].esc));
    end
    a_fl = 1'b0; a_sc = 1'b0;

    // Asynchronous reset in the middle of a FULL stall
    a_iv = 1'b1; a_ic = 8'h03; a_id = 96'h55; a_or = 1'b0;
    tick();
    a_id = 96'h56;
    tick();
    chk("mid_a_ir_full", 128'(a_ir), 128'(0));
    #2;
    clrn = 1'b0;
    #1;
    chk("mid_a_ov", 128'(a_ov), 128'(0));
    chk("mid_a_oc", 128'(a_oc), 128'(0));
    chk("mid_a_od", 128'(a_od), 128'(0));
    chk("mid_a_ir", 128'(a_ir), 128'(1));
    chk("mid_a_cnt", 128'(a_cnt), 128'(0));
    a_iv = 1'b0;
    tick();
    clrn = 1'b1;
    tick();
    chk("mid_a_ov_rel", 128'(a_ov), 128'(0));
    chk("mid_a_oc_rel", 128'(a_oc), 128'(0));

    // Combinational-ready variant
    for (int i = 0; i < 6; i++) begin
      b_iv = 1'(b_iv_t[i]);
      b_ic = 8'h03;
      b_id = 96'(b_d[i]);
      b_or = 1'(b_ordy[i]);
      #1;
      chk($sformatf("b%0d_ir", i), 128'(b_ir), 128'(b_eir[i]));
      tick();
      chk($sformatf("b%0d_ov", i), 128'(b_ov), 128'(b_eov[i]));
      chk($sformatf("b%0d_oc", i), 128'(b_oc), 128'(b_eov[i] != 0 ? 8'h03 : 8'h00));
      chk($sformatf("b%0d_od", i), 128'(b_od), 128'(b_eod[i]));
    end

    // Narrow counter saturation and clear priority
    c_iv = 1'b1; c_ic = 8'h03; c_id = 96'h7; c_or = 1'b0;
    tick();
    c_iv = 1'b0;
    chk("c_cnt_start", 128'(c_cnt), 128'(0));
    repeat (14) tick();
    chk("c_cnt_14", 128'(c_cnt), 128'(14));
    repeat (6) tick();
    chk("c_cnt_sat", 128'(c_cnt), 128'(15));
    c_sc = 1'b1;
    tick();
    chk("c_clr_with_stall", 128'(c_cnt), 128'(0));
    c_sc = 1'b0;
    repeat (3) tick();
    chk("c_cnt_3", 128'(c_cnt), 128'(3));
    c_sc = 1'b1; c_or = 1'b1;
    tick();
    chk("c_clr_pulse", 128'(c_cnt), 128'(0));
    chk("c_drained", 128'(c_ov), 128'(0));
    c_sc = 1'b0;
    tick();
    chk("c_cnt_idle", 128'(c_cnt), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
